// File: rtl/mem_bus_responder_if.sv
// Processor-side memory bus and preload port of mem_bus_responder.
// mbr is a shared tri-state net: the master drives it only while we=1.
interface mem_bus_responder_if;
    logic [7:0] mar;
    wire  [7:0] mbr;
    logic       we;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic [7:0] out_port;
    logic       out_valid;
    logic [7:0] w_masterData;

    assign mbr = we ? w_masterData : 8'hzz;

    modport master (
        output mar, we, w_masterData, load_valid, load_addr, load_data,
        input  load_ready, out_port, out_valid,
        inout  mbr
    );

    modport slave (
        input  mar, we, load_valid, load_addr, load_data,
        output load_ready, out_port, out_valid,
        inout  mbr
    );
endinterface

// File: rtl/mem_bus_responder.sv
// 256x8 memory answering a processor bus with combinational reads, plus a
// memory-mapped timer (0xFE), write counter (0xFD) and output port (0xFF).
module mem_bus_responder #(
    parameter int TIMER_DIV = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    mem_bus_responder_if.slave bus
);
    localparam int PRESCALE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(TIMER_DIV - 1);
    localparam logic [7:0] ADDR_WRCOUNT = 8'hFD;
    localparam logic [7:0] ADDR_TIMER   = 8'hFE;
    localparam logic [7:0] ADDR_OUTPORT = 8'hFF;

    logic [7:0]            r_ram [0:255];
    logic [7:0]            r_timer;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [7:0]            r_wrCount;
    logic [7:0]            r_outPort;
    logic                  r_outValid;

    logic [7:0]            w_readValue;
    logic                  w_ramBusWrite;
    logic                  w_loadFire;

    // The loader only gets the RAM port in cycles the processor is not writing.
    assign bus.load_ready = reset_n & ~bus.we;
    assign w_loadFire     = bus.load_valid & bus.load_ready;
    assign w_ramBusWrite  = reset_n & bus.we
                          & (bus.mar != ADDR_WRCOUNT) & (bus.mar != ADDR_TIMER);

    always_comb begin
        w_readValue = r_ram[bus.mar];
        if (bus.mar == ADDR_TIMER)
            w_readValue = r_timer;
        else if (bus.mar == ADDR_WRCOUNT)
            w_readValue = r_wrCount;
    end

    assign bus.mbr = bus.we ? 8'hzz : w_readValue;

    // RAM has no reset; edges seen while reset_n is low are simply ignored.
    always_ff @(posedge clock) begin
        if (w_ramBusWrite)
            r_ram[bus.mar] <= bus.mbr;
        else if (w_loadFire)
            r_ram[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale <= '0;
            r_timer    <= 8'h00;
        end else if (r_prescale == PRESCALE_MAX) begin
            r_prescale <= '0;
            r_timer    <= r_timer + 8'd1;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wrCount  <= 8'h00;
            r_outPort  <= 8'h00;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= bus.we && (bus.mar == ADDR_OUTPORT);
            if (bus.we)
                r_wrCount <= r_wrCount + 8'd1;
            if (bus.we && (bus.mar == ADDR_OUTPORT))
                r_outPort <= bus.mbr;
        end
    end

    assign bus.out_port  = r_outPort;
    assign bus.out_valid = r_outValid;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: a vector table of preloads, writes
// and reads, then hand-written sequences for handshake, reset and timer corners.
module tb_mem_bus_responder;
    typedef enum logic [1:0] {OP_LOAD, OP_WRITE, OP_READ} opKind_t;
    typedef struct {
        opKind_t    op;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] expRead;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n;
    int         vectorCount = 0;
    int         missCount = 0;
    logic [7:0] expQueue [$];
    vec_t       vecs [$];

    mem_bus_responder_if bus();

    mem_bus_responder #(.TIMER_DIV(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%02h, want 0x%02h", name, actual, expected);
        end
    endtask

    task automatic checkRead(input string name);
        logic [7:0] expVal;
        if (expQueue.size() == 0) begin
            vectorCount++;
            missCount++;
            $display("[TB] FAIL %s: scoreboard empty, got 0x%02h, want an expected entry", name, bus.mbr);
        end else begin
            expVal = expQueue.pop_front();
            checkOutput(name, bus.mbr, expVal);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] expected);
        @(negedge clock);
        bus.we  = 1'b0;
        bus.mar = addr;
        expQueue.push_back(expected);
        #1;
    endtask

    task automatic readAt(input string name, input logic [7:0] addr, input logic [7:0] expected);
        applyStimulus(addr, expected);
        checkRead(name);
    endtask

    task automatic busWrite(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clock);
        bus.we           = 1'b1;
        bus.mar          = addr;
        bus.w_masterData = data;
        @(negedge clock);
        bus.we = 1'b0;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [7:0] data);
        bit accepted = 1'b0;
        @(negedge clock);
        bus.load_valid = 1'b1;
        bus.load_addr  = addr;
        bus.load_data  = data;
        for (int k = 0; k < 20 && !accepted; k++) begin
            #1;
            if (bus.load_ready) begin
                @(posedge clock);
                accepted = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        @(negedge clock);
        bus.load_valid = 1'b0;
        if (!accepted) begin
            vectorCount++;
            missCount++;
            $display("[TB] FAIL preload 0x%02h: load_ready stayed 0, want 1 within 20 cycles", addr);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at 200000, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs.push_back('{OP_LOAD,  8'h00, 8'h4F, 8'h00});
        vecs.push_back('{OP_LOAD,  8'h0F, 8'h11, 8'h00});
        vecs.push_back('{OP_READ,  8'h00, 8'h00, 8'h4F});
        vecs.push_back('{OP_READ,  8'h0F, 8'h00, 8'h11});
        vecs.push_back('{OP_LOAD,  8'h10, 8'h01, 8'h00});
        vecs.push_back('{OP_LOAD,  8'hF0, 8'hA5, 8'h00});
        vecs.push_back('{OP_LOAD,  8'hF2, 8'h00, 8'h00});
        vecs.push_back('{OP_READ,  8'hF0, 8'h00, 8'hA5});
        vecs.push_back('{OP_READ,  8'hFD, 8'h00, 8'h00});
        vecs.push_back('{OP_WRITE, 8'h20, 8'hC3, 8'h00});
        vecs.push_back('{OP_READ,  8'h20, 8'h00, 8'hC3});
        vecs.push_back('{OP_READ,  8'hFD, 8'h00, 8'h01});
        vecs.push_back('{OP_WRITE, 8'hFD, 8'h55, 8'h00});
        vecs.push_back('{OP_READ,  8'hFD, 8'h00, 8'h02});
        vecs.push_back('{OP_WRITE, 8'hFE, 8'h99, 8'h00});
        vecs.push_back('{OP_READ,  8'hFD, 8'h00, 8'h03});
        vecs.push_back('{OP_WRITE, 8'hF1, 8'h3C, 8'h00});
        vecs.push_back('{OP_READ,  8'hF1, 8'h00, 8'h3C});
        vecs.push_back('{OP_READ,  8'h10, 8'h00, 8'h01});
        vecs.push_back('{OP_LOAD,  8'h20, 8'h5A, 8'h00});
        vecs.push_back('{OP_READ,  8'h20, 8'h00, 8'h5A});
        vecs.push_back('{OP_READ,  8'hFD, 8'h00, 8'h04});

        reset_n          = 1'b0;
        bus.we           = 1'b0;
        bus.mar          = 8'hFE;
        bus.w_masterData = 8'h00;
        bus.load_valid   = 1'b0;
        bus.load_addr    = 8'h00;
        bus.load_data    = 8'h00;
        #12;
        checkOutput("reset out_port", bus.out_port, 8'h00);
        checkOutput("reset out_valid", {7'b0, bus.out_valid}, 8'h00);
        checkOutput("reset load_ready", {7'b0, bus.load_ready}, 8'h00);
        readAt("reset timer readback", 8'hFE, 8'h00);
        readAt("reset counter readback", 8'hFD, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_LOAD:  preload(vecs[i].addr, vecs[i].data);
                OP_WRITE: busWrite(vecs[i].addr, vecs[i].data);
                default:  readAt($sformatf("vec%0d read 0x%02h", i, vecs[i].addr), vecs[i].addr, vecs[i].expRead);
            endcase
        end

        // Single write to the output port: one out_valid cycle, processor owns mbr.
        @(negedge clock);
        bus.we           = 1'b1;
        bus.mar          = 8'hFF;
        bus.w_masterData = 8'h2A;
        #1;
        checkOutput("mbr released while we=1", bus.mbr, 8'h2A);
        checkOutput("load_ready during write", {7'b0, bus.load_ready}, 8'h00);
        @(posedge clock); #1;
        checkOutput("out_port after write", bus.out_port, 8'h2A);
        checkOutput("out_valid pulse", {7'b0, bus.out_valid}, 8'h01);
        @(negedge clock);
        bus.we = 1'b0;
        @(posedge clock); #1;
        checkOutput("out_valid drops", {7'b0, bus.out_valid}, 8'h00);
        checkOutput("out_port holds", bus.out_port, 8'h2A);
        readAt("ram 0xFF after write", 8'hFF, 8'h2A);
        readAt("counter after 0xFF write", 8'hFD, 8'h05);

        // Held write to 0xFF for three edges gives three writes and three pulses.
        @(negedge clock);
        bus.we  = 1'b1;
        bus.mar = 8'hFF;
        for (int i = 1; i <= 3; i++) begin
            bus.w_masterData = 8'(i);
            @(posedge clock); #1;
            checkOutput($sformatf("held write %0d out_valid", i), {7'b0, bus.out_valid}, 8'h01);
            checkOutput($sformatf("held write %0d out_port", i), bus.out_port, 8'(i));
            @(negedge clock);
        end
        bus.we = 1'b0;
        @(posedge clock); #1;
        checkOutput("held write out_valid drops", {7'b0, bus.out_valid}, 8'h00);
        readAt("counter after held write", 8'hFD, 8'h08);

        // Bus write stalls a pending preload; a same-cycle read sees the old data.
        @(negedge clock);
        bus.we           = 1'b1;
        bus.mar          = 8'h80;
        bus.w_masterData = 8'h33;
        bus.load_valid   = 1'b1;
        bus.load_addr    = 8'h10;
        bus.load_data    = 8'h77;
        #1;
        checkOutput("load_ready stalled by write", {7'b0, bus.load_ready}, 8'h00);
        @(negedge clock);
        bus.we  = 1'b0;
        bus.mar = 8'h10;
        #1;
        checkOutput("load_ready after write", {7'b0, bus.load_ready}, 8'h01);
        expQueue.push_back(8'h01);
        checkRead("old value during preload");
        @(posedge clock); #1;
        expQueue.push_back(8'h77);
        checkRead("preload visible after edge");
        @(negedge clock);
        bus.load_valid = 1'b0;
        readAt("bus write won arbitration", 8'h80, 8'h33);
        readAt("counter after stall write", 8'hFD, 8'h09);

        // Asynchronous reset clears registers mid-cycle but leaves RAM intact.
        @(negedge clock);
        bus.we           = 1'b1;
        bus.mar          = 8'hFF;
        bus.w_masterData = 8'h2A;
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset out_port", bus.out_port, 8'h00);
        checkOutput("async reset out_valid", {7'b0, bus.out_valid}, 8'h00);
        checkOutput("async reset load_ready", {7'b0, bus.load_ready}, 8'h00);
        readAt("async reset timer", 8'hFE, 8'h00);
        readAt("async reset counter", 8'hFD, 8'h00);
        readAt("ram 0xFF survives reset", 8'hFF, 8'h2A);
        @(negedge clock);
        bus.we           = 1'b1;
        bus.mar          = 8'hF2;
        bus.w_masterData = 8'hEE;
        bus.load_valid   = 1'b1;
        bus.load_addr    = 8'hF2;
        bus.load_data    = 8'h44;
        @(negedge clock);
        bus.we         = 1'b0;
        bus.load_valid = 1'b0;
        readAt("write and preload during reset dropped", 8'hF2, 8'h00);
        readAt("counter untouched in reset", 8'hFD, 8'h00);

        // Timer with TIMER_DIV=4: 256 increments in 1024 cycles wrap back to 0.
        bus.mar = 8'hFE;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("timer after 3 cycles", bus.mbr, 8'h00);
        @(posedge clock); #1;
        checkOutput("timer after 4 cycles", bus.mbr, 8'h01);
        repeat (1020) @(posedge clock);
        #1;
        checkOutput("timer after 1024 cycles", bus.mbr, 8'h00);
        repeat (8) @(posedge clock);
        #1;
        checkOutput("timer after 1032 cycles", bus.mbr, 8'h02);

        // 257 held writes wrap the counter; data written to 0xFD is ignored.
        @(negedge clock);
        bus.we           = 1'b1;
        bus.mar          = 8'h80;
        bus.w_masterData = 8'h77;
        repeat (257) @(posedge clock);
        @(negedge clock);
        bus.we = 1'b0;
        readAt("counter after 257 writes", 8'hFD, 8'h01);
        readAt("ram 0x80 after held write", 8'h80, 8'h77);
        busWrite(8'hFD, 8'h55);
        readAt("counter ignores 0xFD data", 8'hFD, 8'h02);

        // Preloading 0xFF touches only RAM, never the port or the counter.
        preload(8'hFF, 8'h99);
        readAt("preload 0xFF ram", 8'hFF, 8'h99);
        readAt("counter after preload", 8'hFD, 8'h02);
        checkOutput("out_port after preload", bus.out_port, 8'h00);
        checkOutput("out_valid after preload", {7'b0, bus.out_valid}, 8'h00);

        if (expQueue.size() != 0) begin
            vectorCount++;
            missCount++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, want 0", expQueue.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
